// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds the default parameter values, the layout of one prefetch FIFO entry
// and the encoding of the derived debug state.
package fetch_prefetch_unit_pkg;

   localparam int unsigned PKG_XLEN     = 32;
   localparam int unsigned DEF_PC_STEP  = 1;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam int unsigned DEF_DEPTH    = 4;
   localparam int unsigned DEF_MAX_OUT  = 2;

   // One buffered instruction: PC in the upper half, instruction word in the lower half.
   typedef struct packed {
      logic [PKG_XLEN-1:0] pc;
      logic [PKG_XLEN-1:0] inst;
   } fifo_entry_t;

   // Observation-only state; the datapath never decodes it.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // no credit to issue a request
      ST_FETCH = 2'd1,   // credit available, requests may issue
      ST_DRAIN = 2'd2    // stale responses still to be discarded
   } fetch_state_e;

endpackage

// File: rtl/fetch_prefetch_unit_sync_fifo.sv
// Synchronous FIFO used as the prefetch buffer.
// Ports:
//   clk     in  clock
//   rst_i   in  synchronous active-high reset
//   flush_i in  drop every entry (wins over push/pop)
//   push_i  in  write data_i at the tail
//   data_i  in  WIDTH-bit entry
//   pop_i   in  remove the head entry
//   valid_o out head entry present
//   data_o  out head entry (zero while empty)
//   count_o out number of entries held
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic                       valid_o,
   output logic [WIDTH-1:0]           data_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
   logic             empty_s, full_s, push_s, pop_s;

   assign empty_s = (wr_q == rd_q);
   assign full_s  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop_s   = pop_i && !empty_s;
   // A push into a full FIFO is accepted when the head leaves in the same cycle.
   assign push_s  = push_i && !flush_i && (!full_s || pop_s);

   // Next pointer values; flush returns both pointers to the origin.
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush_i) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         wr_d = push_s ? wr_q + (AW+1)'(1) : wr_q;
         rd_d = pop_s  ? rd_q + (AW+1)'(1) : rd_q;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Entry storage; contents are only ever read while the slot is occupied.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_q[AW-1:0]] <= data_i;
      end
   end

   assign valid_o = !empty_s;
   assign data_o  = empty_s ? '0 : mem_q[rd_q[AW-1:0]];
   assign count_o = wr_q - rd_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order requests to a
// variable-latency instruction memory, buffers responses and presents {pc,inst}
// to the decode stage. Redirects flush the buffer and discard in-flight responses.
// Ports:
//   clk            in  clock
//   rst_n          in  synchronous reset, active HIGH despite the name
//   redirect       in  restart fetch at redirect_pc
//   redirect_pc    in  new fetch address
//   imem_req_valid out request valid
//   imem_req_ready in  memory accepts request
//   imem_req_addr  out request address (fetch PC)
//   imem_rsp_valid in  response valid, always accepted, in request order
//   imem_rsp_data  in  instruction word
//   inst_valid     out buffered head valid
//   inst_ready     in  decode accepts the head
//   inst_data      out head instruction
//   inst_pc        out head PC
module fetch_prefetch_unit
   import fetch_prefetch_unit_pkg::*;
#(
   parameter int unsigned      XLEN     = PKG_XLEN,
   parameter int unsigned      PC_STEP  = DEF_PC_STEP,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEF_RESET_PC),
   parameter int unsigned      DEPTH    = DEF_DEPTH,
   parameter int unsigned      MAX_OUT  = DEF_MAX_OUT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc
);

   // Counter width: holds 0..DEPTH, and MAX_OUT never exceeds DEPTH.
   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]     out_q, out_d, drop_q, drop_d;
   logic [CW-1:0]     fifo_count_s;
   logic [CW:0]       occupancy_s;
   logic [2*XLEN-1:0] fifo_head_s;
   logic              credit_s, req_valid_s, req_hs_s, push_s, pop_s, drop_any_s;
   fetch_state_e      state_s;

   // Buffered entries plus in-flight requests may never exceed the FIFO size,
   // so every response that is kept is guaranteed a slot.
   assign occupancy_s = {1'b0, fifo_count_s} + {1'b0, out_q};
   assign credit_s    = (out_q < CW'(MAX_OUT)) && (occupancy_s < (CW+1)'(DEPTH));
   assign req_valid_s = credit_s && !redirect && !rst_n;
   assign req_hs_s    = req_valid_s && imem_req_ready;
   assign drop_any_s  = (drop_q != '0);
   assign push_s      = imem_rsp_valid && !drop_any_s && !redirect;
   assign pop_s       = inst_valid && inst_ready;

   // Outstanding / drop counters and both PC registers, next-state.
   always_comb begin
      out_d      = out_q;
      drop_d     = drop_q;
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      if (req_hs_s && !imem_rsp_valid) begin
         out_d = out_q + CW'(1);
      end else if (!req_hs_s && imem_rsp_valid) begin
         out_d = out_q - CW'(1);
      end else begin
         out_d = out_q;
      end
      if (redirect) begin
         // Everything still in flight after this cycle is stale.
         drop_d     = out_d;
         fetch_pc_d = redirect_pc;
         rsp_pc_d   = redirect_pc;
      end else begin
         drop_d     = (imem_rsp_valid && drop_any_s) ? drop_q - CW'(1) : drop_q;
         fetch_pc_d = req_hs_s ? fetch_pc_q + XLEN'(PC_STEP) : fetch_pc_q;
         rsp_pc_d   = push_s   ? rsp_pc_q + XLEN'(PC_STEP)   : rsp_pc_q;
      end
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         out_q      <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
      end
   end

   sync_fifo #(
      .WIDTH (2*XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_i   (rst_n),
      .flush_i (redirect),
      .push_i  (push_s),
      .data_i  ({rsp_pc_q, imem_rsp_data}),
      .pop_i   (pop_s),
      .valid_o (inst_valid),
      .data_o  (fifo_head_s),
      .count_o (fifo_count_s)
   );

   assign imem_req_valid = req_valid_s;
   assign imem_req_addr  = fetch_pc_q;
   assign inst_pc        = fifo_head_s[2*XLEN-1:XLEN];
   assign inst_data      = fifo_head_s[XLEN-1:0];

   // Derived debug state.
   always_comb begin
      state_s = ST_IDLE;
      if (drop_any_s) begin
         state_s = ST_DRAIN;
      end else if (credit_s) begin
         state_s = ST_FETCH;
      end else begin
         state_s = ST_IDLE;
      end
   end

   fetch_prefetch_unit_checker #(
      .DEPTH   (DEPTH),
      .MAX_OUT (MAX_OUT),
      .CW      (CW)
   ) u_chk (
      .clk         (clk),
      .rst_i       (rst_n),
      .state_i     (state_s),
      .out_i       (out_q),
      .count_i     (fifo_count_s),
      .rsp_valid_i (imem_rsp_valid),
      .req_valid_i (req_valid_s)
   );

endmodule

// Protocol and invariant checks for the fetch unit.
module fetch_prefetch_unit_checker
   import fetch_prefetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned MAX_OUT = 2,
   parameter int          CW      = 3
) (
   input logic          clk,
   input logic          rst_i,
   input fetch_state_e  state_i,
   input logic [CW-1:0] out_i,
   input logic [CW-1:0] count_i,
   input logic          rsp_valid_i,
   input logic          req_valid_i
);

   a_out_bound: assert property (@(posedge clk) disable iff (rst_i) out_i <= CW'(MAX_OUT))
      else $error("outstanding count exceeds limit");
   a_fifo_bound: assert property (@(posedge clk) disable iff (rst_i) count_i <= CW'(DEPTH))
      else $error("prefetch fifo overflow");
   a_rsp_expected: assert property (@(posedge clk) disable iff (rst_i) rsp_valid_i |-> (out_i != '0))
      else $error("response with no request outstanding");
   a_idle_quiet: assert property (@(posedge clk) disable iff (rst_i) (state_i == ST_IDLE) |-> !req_valid_i)
      else $error("request issued without credit");

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: a cycle table for streaming and stall,
// plus hand sequences for redirect, reset mid-stream and PC wrap.
module tb_fetch_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        req_valid, req_ready = 1'b1;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        inst_valid, inst_ready = 1'b1;
   logic [31:0] inst_data, inst_pc;
   logic [2:0]  lat_idx = 3'd0;   // memory latency minus one

   logic        w_req_valid, w_rsp_valid, w_inst_valid;
   logic [31:0] w_req_addr, w_rsp_addr, w_inst_data, w_inst_pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'hC0DE_1234;
   endfunction

   fetch_prefetch_unit dut (
      .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
      .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
   );

   fetch_prefetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .redirect(1'b0), .redirect_pc(32'h0),
      .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
      .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(mdata(w_rsp_addr)),
      .inst_valid(w_inst_valid), .inst_ready(1'b1), .inst_data(w_inst_data), .inst_pc(w_inst_pc)
   );

   // Memory model: fixed-latency pipeline of accepted requests, cleared by reset.
   logic [7:0]  pv;
   logic [31:0] pa [8];
   always @(posedge clk) begin
      if (rst_n) pv <= 8'h00;
      else       pv <= {pv[6:0], req_valid && req_ready};
      pa[0] <= req_addr;
      for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
   end
   assign rsp_valid = pv[lat_idx];
   assign rsp_data  = mdata(pa[lat_idx]);

   // One-cycle memory for the wrap instance.
   always @(posedge clk) begin
      if (rst_n) w_rsp_valid <= 1'b0;
      else       w_rsp_valid <= w_req_valid;
      w_rsp_addr <= w_req_addr;
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [2:0] li);
      rst_n = 1'b1; redirect = 1'b0; inst_ready = 1'b1; lat_idx = li;
      step(); step();
      rst_n = 1'b0;
   endtask

   // Waits (bounded) for the next head and checks its PC and data; pops it.
   task automatic wait_head(input string name, input logic [31:0] exp_pc);
      bit seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (inst_valid) begin
            seen = 1'b1;
            chk32({name, "_pc"}, inst_pc, exp_pc);
            chk32({name, "_data"}, inst_data, mdata(exp_pc));
         end
         step();
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL %s timeout actual=no_inst required=pc_%h", name, exp_pc);
      end
   endtask

   // Two stale requests in flight, then one or two redirects.
   task automatic run_redirect(input bit two);
      logic [31:0] target;
      do_reset(3'd2);
      step(); step();
      redirect = 1'b1; redirect_pc = 32'h40;
      @(negedge clk);
      chk1("t3_redir_noreq", req_valid, 1'b0);
      step();
      redirect = 1'b0;
      target = 32'h40;
      if (two) begin
         redirect = 1'b1; redirect_pc = 32'h60;
         @(negedge clk);
         chk1("t3b_redir2_noreq", req_valid, 1'b0);
         chk1("t3b_redir2_empty", inst_valid, 1'b0);
         step();
         redirect = 1'b0;
         target = 32'h60;
      end
      wait_head(two ? "t3b_first" : "t3_first", target);
      wait_head(two ? "t3b_second" : "t3_second", target + 32'h1);
   endtask

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        chk;
      logic        exp_rv;
      logic [31:0] exp_addr;
      logic        exp_iv;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(logic rst, logic rdy, logic chk, logic rv,
                               logic [31:0] addr, logic iv, logic [31:0] pc);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.chk = chk; v.exp_rv = rv;
      v.exp_addr = addr; v.exp_iv = iv; v.exp_pc = pc;
      vecs.push_back(v);
   endfunction

   initial begin
      // Streaming with a one-cycle memory: head PC trails the request PC by two.
      add(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      add(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 32'd0);
      for (int k = 2; k < 8; k++) add(1'b0, 1'b1, 1'b1, 1'b1, 32'(k), 1'b1, 32'(k - 2));
      // Stall from reset for ten cycles: FIFO fills to four, requests stop at PC 4.
      add(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      add(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 32'd0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 32'd2, 1'b1, 32'd0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 32'd3, 1'b1, 32'd0);
      for (int k = 4; k < 10; k++) add(1'b0, 1'b0, 1'b1, 1'b0, 32'd4, 1'b1, 32'd0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 32'd4, 1'b1, 32'd0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 32'd4, 1'b1, 32'd1);
      for (int k = 5; k < 9; k++) add(1'b0, 1'b1, 1'b1, 1'b1, 32'(k), 1'b1, 32'(k - 3));

      #1;
      foreach (vecs[i]) begin
         rst_n = vecs[i].rst;
         inst_ready = vecs[i].rdy;
         @(negedge clk);
         chk1($sformatf("vec%0d_req_valid", i), req_valid, vecs[i].exp_rv);
         if (vecs[i].chk) begin
            chk32($sformatf("vec%0d_req_addr", i), req_addr, vecs[i].exp_addr);
            chk1($sformatf("vec%0d_inst_valid", i), inst_valid, vecs[i].exp_iv);
            if (vecs[i].exp_iv) begin
               chk32($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].exp_pc);
               chk32($sformatf("vec%0d_inst_data", i), inst_data, mdata(vecs[i].exp_pc));
            end else if (vecs[i].rst) begin
               chk32($sformatf("vec%0d_rst_pc", i), inst_pc, 32'h0);
               chk32($sformatf("vec%0d_rst_data", i), inst_data, 32'h0);
            end
         end
         step();
      end

      // Latency-3 memory, redirect with two stale responses in flight.
      run_redirect(1'b0);
      // Second redirect while the first one is still draining.
      run_redirect(1'b1);

      // Redirect coinciding with a response and a pop.
      do_reset(3'd0);
      for (int k = 0; k < 6; k++) step();
      redirect = 1'b1; redirect_pc = 32'h80;
      @(negedge clk);
      chk1("t4_noreq", req_valid, 1'b0);
      chk1("t4_rsp_present", rsp_valid, 1'b1);
      chk1("t4_head_valid", inst_valid, 1'b1);
      chk32("t4_head_pc", inst_pc, 32'd4);
      step();
      redirect = 1'b0;
      @(negedge clk);
      chk1("t4_n1_inst_valid", inst_valid, 1'b0);
      chk1("t4_n1_req_valid", req_valid, 1'b1);
      chk32("t4_n1_req_addr", req_addr, 32'h80);
      step();
      @(negedge clk);
      chk1("t4_n2_inst_valid", inst_valid, 1'b0);
      step();
      wait_head("t4_first", 32'h80);
      wait_head("t4_second", 32'h81);

      // Reset with two requests outstanding.
      do_reset(3'd2);
      step(); step();
      rst_n = 1'b1;
      @(negedge clk);
      chk1("t5_rst_noreq", req_valid, 1'b0);
      step();
      @(negedge clk);
      chk1("t5_rst_inst_valid", inst_valid, 1'b0);
      chk32("t5_rst_addr", req_addr, 32'h0);
      step();
      rst_n = 1'b0;
      wait_head("t5_first", 32'h0);
      wait_head("t5_second", 32'h1);

      // PC wrap on the instance reset to 0xFFFFFFFF.
      do_reset(3'd0);
      @(negedge clk);
      chk1("t6_req_valid", w_req_valid, 1'b1);
      chk32("t6_req_addr0", w_req_addr, 32'hFFFF_FFFF);
      step();
      @(negedge clk);
      chk32("t6_req_addr1", w_req_addr, 32'h0000_0000);
      step();
      @(negedge clk);
      chk1("t6_inst_valid0", w_inst_valid, 1'b1);
      chk32("t6_inst_pc0", w_inst_pc, 32'hFFFF_FFFF);
      chk32("t6_inst_data0", w_inst_data, mdata(32'hFFFF_FFFF));
      step();
      @(negedge clk);
      chk1("t6_inst_valid1", w_inst_valid, 1'b1);
      chk32("t6_inst_pc1", w_inst_pc, 32'h0000_0000);
      chk32("t6_inst_data1", w_inst_data, mdata(32'h0000_0000));
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
